// File: rtl/pcm_uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pcm_uart_pkg
// Brief    : Shared types and constants for the PCM sample UART transmitter.
// Revision : 1.0 - initial release
// ============================================================================
package pcm_uart_pkg;

  // Line-side FSM states; PARITY is only reachable when UART_PARITY_EN is set
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_t;

  localparam int   BITS_PER_BYTE = 8;
  localparam logic START_BIT     = 1'b0;
  localparam logic STOP_BIT      = 1'b1;

  // Pointer width with one extra wrap bit to tell full from empty
  function automatic int clog2_p1(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pcm_sample_fifo.sv
`default_nettype none
// ============================================================================
// Module   : pcm_sample_fifo
// Brief    : Synchronous sample FIFO; extra pointer MSB separates full/empty.
// Revision : 1.0 - initial release
// ============================================================================
module pcm_sample_fifo
  import pcm_uart_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_data,
  output logic              o_full,
  output logic              o_empty
);

  localparam int PTR_W  = clog2_p1(FIFO_DEPTH);
  localparam int ADDR_W = PTR_W - 1;

  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic              w_do_push;
  logic              w_do_pop;

  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[PTR_W-1] != r_rd_ptr[PTR_W-1]) &&
                     (r_wr_ptr[ADDR_W-1:0] == r_rd_ptr[ADDR_W-1:0]);
  assign o_data    = r_mem[r_rd_ptr[ADDR_W-1:0]];

  // Pointers advance on accepted push/pop and wrap naturally
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
    end
  end

  // Storage needs no reset: empty pointers hide stale contents
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[ADDR_W-1:0]] <= i_data;
  end

endmodule
`default_nettype wire

// File: rtl/pcm_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : pcm_uart_tx
// Brief    : Buffers PCM samples and sends them MSB byte first as UART frames.
//            8N1 by default; define UART_PARITY_EN for 8E1 framing.
// Revision : 1.0 - initial release
// ============================================================================
module pcm_uart_tx
  import pcm_uart_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int CLK_DIV    = 434,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  input  logic              ovf_clr,
  output logic              tx,
  output logic              busy,
  output logic              overflow
);

  localparam int               NBYTES    = DATA_W / BITS_PER_BYTE;
  localparam int               CNT_W     = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(CLK_DIV - 1);
  localparam logic [1:0]       LAST_BYTE = 2'(NBYTES - 1);

  uart_state_t       r_state;
  logic [CNT_W-1:0]  r_baud_cnt;
  logic [2:0]        r_bit_idx;
  logic [1:0]        r_byte_idx;
  logic [DATA_W-1:0] r_sample;
  logic [7:0]        r_byte;
  logic              r_tx;
  logic              r_ovf;
  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;
  logic              w_bit_end;
  logic [DATA_W-1:0] w_fifo_data;

  assign w_push    = s_valid && !w_full;
  assign w_bit_end = (r_baud_cnt == LAST_CNT);
  assign s_ready   = !w_full;
  assign tx        = r_tx;
  assign busy      = (r_state != ST_IDLE) || !w_empty;
  assign overflow  = r_ovf;

  pcm_sample_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (s_data),
    .i_pop   (w_pop),
    .o_data  (w_fifo_data),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Pop when idle, or at the end of the last stop bit to chain samples gaplessly
  always_comb begin
    w_pop = 1'b0;
    if (!w_empty) begin
      if (r_state == ST_IDLE) begin
        w_pop = 1'b1;
      end else if (r_state == ST_STOP && w_bit_end && r_byte_idx == LAST_BYTE) begin
        w_pop = 1'b1;
      end
    end
  end

  // Sticky overflow: a drop in the same cycle as a clear keeps the flag set
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (s_valid && w_full) begin
      r_ovf <= 1'b1;
    end else if (ovf_clr) begin
      r_ovf <= 1'b0;
    end
  end

  // Line FSM with baud counter and byte shifter; tx is registered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_baud_cnt <= '0;
      r_bit_idx  <= '0;
      r_byte_idx <= '0;
      r_sample   <= '0;
      r_byte     <= '0;
      r_tx       <= STOP_BIT;
    end else begin
      if (r_state != ST_IDLE) begin
        r_baud_cnt <= w_bit_end ? '0 : r_baud_cnt + CNT_W'(1);
      end
      case (r_state)
        ST_IDLE: begin
          if (w_pop) begin
            r_sample   <= w_fifo_data;
            r_byte_idx <= '0;
            r_baud_cnt <= '0;
            r_tx       <= START_BIT;
            r_state    <= ST_START;
          end
        end
        ST_START: begin
          if (w_bit_end) begin
            // Current byte is always the top byte; earlier bytes are shifted out
            r_byte    <= r_sample[DATA_W-1 -: BITS_PER_BYTE];
            r_tx      <= r_sample[DATA_W-BITS_PER_BYTE];
            r_bit_idx <= '0;
            r_state   <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (w_bit_end) begin
            if (r_bit_idx == 3'd7) begin
`ifdef UART_PARITY_EN
              r_tx    <= ^r_byte;
              r_state <= ST_PARITY;
`else
              r_tx    <= STOP_BIT;
              r_state <= ST_STOP;
`endif
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
              r_tx      <= r_byte[r_bit_idx + 3'd1];
            end
          end
        end
`ifdef UART_PARITY_EN
        ST_PARITY: begin
          if (w_bit_end) begin
            r_tx    <= STOP_BIT;
            r_state <= ST_STOP;
          end
        end
`endif
        ST_STOP: begin
          if (w_bit_end) begin
            if (r_byte_idx < LAST_BYTE) begin
              r_byte_idx <= r_byte_idx + 2'd1;
              r_sample   <= r_sample << BITS_PER_BYTE;
              r_tx       <= START_BIT;
              r_state    <= ST_START;
            end else if (w_pop) begin
              r_sample   <= w_fifo_data;
              r_byte_idx <= '0;
              r_tx       <= START_BIT;
              r_state    <= ST_START;
            end else begin
              r_tx    <= STOP_BIT;
              r_state <= ST_IDLE;
            end
          end
        end
        default: begin
          r_tx    <= STOP_BIT;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pcm_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_pcm_uart_tx
// Brief    : Self-checking bench for pcm_uart_tx (CLK_DIV=4, DATA_W=16,
//            FIFO_DEPTH=4); honours UART_PARITY_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pcm_uart_tx;

  localparam int DATA_W     = 16;
  localparam int CLK_DIV    = 4;
  localparam int FIFO_DEPTH = 4;
  localparam int NB         = DATA_W / 8;
`ifdef UART_PARITY_EN
  localparam int FRAME = 11 * CLK_DIV;
`else
  localparam int FRAME = 10 * CLK_DIV;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              s_valid;
  logic [DATA_W-1:0] s_data;
  logic              s_ready;
  logic              ovf_clr;
  logic              tx;
  logic              busy;
  logic              overflow;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  bit mdl_on = 1'b0;

  always #5 clk = ~clk;

  pcm_uart_tx #(
    .DATA_W     (DATA_W),
    .CLK_DIV    (CLK_DIV),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .s_valid  (s_valid),
    .s_data   (s_data),
    .s_ready  (s_ready),
    .ovf_clr  (ovf_clr),
    .tx       (tx),
    .busy     (busy),
    .overflow (overflow)
  );

  // Free-running edge counter: at a negedge, cyc is the index of the last posedge
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- Behavioural model: sample queue + per-cycle line queue ---
  logic [DATA_W-1:0] m_fifo[$];
  bit                m_line[$];
  logic              m_tx    = 1'b1;
  logic              m_busy  = 1'b0;
  logic              m_ready = 1'b1;
  logic              m_ovf   = 1'b0;
  bit                m_full_pre;

  task automatic m_load(input logic [DATA_W-1:0] s);
    logic [7:0] by;
    for (int b = 0; b < NB; b++) begin
      by = s[DATA_W-1-8*b -: 8];
      repeat (CLK_DIV) m_line.push_back(1'b0);
      for (int i = 0; i < 8; i++) repeat (CLK_DIV) m_line.push_back(by[i]);
`ifdef UART_PARITY_EN
      repeat (CLK_DIV) m_line.push_back(^by);
`endif
      repeat (CLK_DIV) m_line.push_back(1'b1);
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_fifo.delete();
      m_line.delete();
      m_tx = 1'b1; m_busy = 1'b0; m_ready = 1'b1; m_ovf = 1'b0;
    end else begin
      m_full_pre = (m_fifo.size() == FIFO_DEPTH);
      if (m_line.size() == 0 && m_fifo.size() > 0) m_load(m_fifo.pop_front());
      if (s_valid && m_full_pre) begin
        m_ovf = 1'b1;
      end else begin
        if (s_valid) m_fifo.push_back(s_data);
        if (ovf_clr) m_ovf = 1'b0;
      end
      if (m_line.size() > 0) begin
        m_tx   = m_line.pop_front();
        m_busy = 1'b1;
      end else begin
        m_tx   = 1'b1;
        m_busy = (m_fifo.size() > 0);
      end
      m_ready = (m_fifo.size() < FIFO_DEPTH);
    end
  end

  initial begin : compare
    forever begin
      @(negedge clk);
      if (!rst && mdl_on) begin
        chk("tx", tx, m_tx);
        chk("busy", busy, m_busy);
        chk("s_ready", s_ready, m_ready);
        chk("overflow", overflow, m_ovf);
      end
    end
  end

  // ---------------- Line decoder (mid-bit sampling) --------------------------
  logic [7:0] dec_q[$];
  int         dec_t[$];
  bit         dec_par[$];
  logic [7:0] exp_q[$];

  initial begin : decoder
    logic [7:0] by;
    int         t0;
    bit         p;
    forever begin
      @(negedge clk);
      if (!rst && tx === 1'b0) begin
        t0 = cyc;
        repeat (CLK_DIV/2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (CLK_DIV) @(negedge clk);
          by[i] = tx;
        end
        p = 1'b0;
`ifdef UART_PARITY_EN
        repeat (CLK_DIV) @(negedge clk);
        p = tx;
`endif
        repeat (CLK_DIV) @(negedge clk);
        dec_q.push_back(by);
        dec_t.push_back(t0);
        dec_par.push_back(p);
      end
    end
  end

  int busy_fall = -1;
  bit prev_busy = 1'b0;
  always @(negedge clk) begin
    if (prev_busy && !busy) busy_fall = cyc;
    prev_busy = busy;
  end

  // ---------------- Stimulus helpers ----------------------------------------
  task automatic push(input logic [DATA_W-1:0] d, output int acc);
    s_valid = 1'b1;
    s_data  = d;
    @(negedge clk);
    acc = cyc;
    #1 s_valid = 1'b0;
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
    #1;
  endtask

  task automatic wait_idle(input int maxc);
    int k = 0;
    while (busy !== 1'b0 && k < maxc) begin
      @(negedge clk); #1;
      k++;
    end
    chk("idle_timeout", busy, 1'b0);
  endtask

  task automatic clr_dec();
    dec_q.delete(); dec_t.delete(); dec_par.delete();
  endtask

  task automatic chk_dec(input int first_start);
    chk("dec_count", dec_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < dec_q.size(); i++) begin
      chk($sformatf("byte%0d", i), dec_q[i], exp_q[i]);
      if (i > 0) chk($sformatf("frame_gap%0d", i), dec_t[i] - dec_t[i-1], FRAME);
    end
    chk("first_start", (dec_t.size() > 0) ? dec_t[0] : -1, first_start);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // ---------------- Directed tests ------------------------------------------
  initial begin : main
    int a, b, a1, p;
    rst = 1'b1; s_valid = 1'b0; s_data = '0; ovf_clr = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx", tx, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_overflow", overflow, 1'b0);
    chk("rst_s_ready", s_ready, 1'b1);
    #1 rst = 1'b0;
    mdl_on = 1'b1;
    repeat (2) @(negedge clk);
    #1;

    // Single sample
    clr_dec();
    push(16'h12A5, a);
    wait_idle(2000);
    exp_q = {8'h12, 8'hA5};
    chk_dec(a + 1);
    chk("busy_fall", busy_fall, a + 1 + 2*FRAME);

    // Back-to-back samples
    clr_dec();
    push(16'h0001, a);
    push(16'h8000, b);
    wait_idle(2000);
    exp_q = {8'h00, 8'h01, 8'h80, 8'h00};
    chk_dec(a + 1);

    // Overflow: six pushes in a row while idle
    clr_dec();
    push(16'h1111, a1);
    for (int k = 2; k <= 5; k++) push(DATA_W'(16'h1111 * k), b);
    chk("s_ready_full", s_ready, 1'b0);
    push(16'h6666, b);
    chk("overflow_set", overflow, 1'b1);
    ovf_clr = 1'b1;
    @(negedge clk); #1 ovf_clr = 1'b0;
    chk("overflow_clr", overflow, 1'b0);

    // Offer while full in the cycle the FSM pops, plus a clear: drop wins
    p = a1 + 1 + 2*FRAME;
    wait_cyc(p - 1);
    s_valid = 1'b1; s_data = 16'hDEAD; ovf_clr = 1'b1;
    @(negedge clk);
    chk("ovf_set_wins", overflow, 1'b1);
    #1 ovf_clr = 1'b0; s_data = 16'hBEEF;
    @(negedge clk);
    #1 s_valid = 1'b0;
    wait_idle(3000);
    exp_q = {8'h11, 8'h11, 8'h22, 8'h22, 8'h33, 8'h33,
             8'h44, 8'h44, 8'h55, 8'h55, 8'hBE, 8'hEF};
    chk_dec(a1 + 1);
    ovf_clr = 1'b1;
    @(negedge clk); #1 ovf_clr = 1'b0;

    // Asynchronous reset during data bit 3 of the first byte
    push(16'h0077, a);
    wait_cyc(a + 18);
    chk("tx_bit3", tx, 1'b0);
    rst = 1'b1;
    #1;
    chk("arst_tx", tx, 1'b1);
    chk("arst_busy", busy, 1'b0);
    chk("arst_s_ready", s_ready, 1'b1);
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    repeat (60) @(negedge clk);
    #1;
    clr_dec();
    push(16'h5A5A, a);
    wait_idle(2000);
    exp_q = {8'h5A, 8'h5A};
    chk_dec(a + 1);

`ifdef UART_PARITY_EN
    // Even parity per byte, 11-bit frames
    clr_dec();
    push(16'h0301, a);
    wait_idle(2000);
    exp_q = {8'h03, 8'h01};
    chk_dec(a + 1);
    chk("par0", (dec_par.size() > 0) ? dec_par[0] : 1'bx, 1'b0);
    chk("par1", (dec_par.size() > 1) ? dec_par[1] : 1'bx, 1'b1);
`endif

    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
